cpu_control_fsm: RTL

Multi-cycle fetch/decode/sequencing stage directly upstream of the 8-bit ALU in the simple processor. It fetches 32-bit instructions (opcode[31:24], dest[23:16], in1[15:8], in2[7:0]) over a request/valid handshake and owns the PC. It drives register-file addresses and write enable, the ALU SEL code, and the two's-complement and immediate mux selects. It resolves j/beq using the ALU ZERO flag.

---
 rtl/cpu_defs_pkg.sv | 44 ++++
 rtl/cpu_decoder.sv | 56 +++++
 rtl/cpu_control_fsm.sv | 130 +++++++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the processor control path.
// Opcodes, ALU select codes, FSM states and instruction field layout.
package cpu_defs;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_SRL   = 8'h08;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SRL  = 3'b100;

    localparam int OP_LSB  = 24;
    localparam int DST_LSB = 16;
    localparam int IN1_LSB = 8;
    localparam int IN2_LSB = 0;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_t;

    typedef struct packed {
        logic [2:0] alu_sel;
        logic       twos_sel;
        logic       imm_sel;
        logic       writes_reg;
        logic       is_jump;
        logic       is_branch;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/cpu_decoder.sv
// Combinational opcode decoder feeding the control FSM.
module cpu_decoder
    import cpu_defs::*;
(
    input  logic [7:0] opcode,
    output dec_t       dec
);

    always_comb begin
        dec = '0;
        unique case (opcode)
            OP_LOADI: begin
                dec.alu_sel    = ALU_PASS;
                dec.imm_sel    = 1'b1;
                dec.writes_reg = 1'b1;
            end
            OP_MOV: begin
                dec.alu_sel    = ALU_PASS;
                dec.writes_reg = 1'b1;
            end
            OP_ADD: begin
                dec.alu_sel    = ALU_ADD;
                dec.writes_reg = 1'b1;
            end
            OP_SUB: begin
                dec.alu_sel    = ALU_ADD;
                dec.twos_sel   = 1'b1;
                dec.writes_reg = 1'b1;
            end
            OP_AND: begin
                dec.alu_sel    = ALU_AND;
                dec.writes_reg = 1'b1;
            end
            OP_OR: begin
                dec.alu_sel    = ALU_OR;
                dec.writes_reg = 1'b1;
            end
            OP_J: begin
                dec.is_jump = 1'b1;
            end
            OP_BEQ: begin
                dec.alu_sel   = ALU_ADD;
                dec.twos_sel  = 1'b1;
                dec.is_branch = 1'b1;
            end
            OP_SRL: begin
                dec.alu_sel    = ALU_SRL;
                dec.writes_reg = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/sequencing control for the 8-bit datapath.
// Owns the PC, fetch handshake, regfile addressing and ALU control.
module cpu_control_fsm
    import cpu_defs::*;
#(
    parameter int PC_W     = 32,
    parameter int ALU_WAIT = 1
) (
    input  logic            CLK,
    input  logic            RESET_N,
    output logic            IMEM_REQ,
    output logic [PC_W-1:0] IMEM_ADDR,
    input  logic            IMEM_VALID,
    input  logic [31:0]     IMEM_DATA,
    input  logic            ALU_ZERO,
    output logic [2:0]      ALU_SEL,
    output logic            TWOS_SEL,
    output logic            IMM_SEL,
    output logic [7:0]      IMM,
    output logic [2:0]      RADDR1,
    output logic [2:0]      RADDR2,
    output logic [2:0]      WADDR,
    output logic            WEN,
    output logic [PC_W-1:0] PC,
    output logic            ILLEGAL
);

    localparam logic [3:0]      WAIT_INIT = 4'(ALU_WAIT - 1);
    localparam logic [PC_W-1:0] PC_STEP   = PC_W'(4);

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    dec_t              dec_q, dec_d;
    logic              ill_q, ill_d;
    logic [3:0]        cnt_q, cnt_d;

    dec_t              dec_in;
    logic [PC_W-1:0]   br_off;
    logic              take;

    cpu_decoder u_dec (
        .opcode (IMEM_DATA[OP_LSB +: 8]),
        .dec    (dec_in)
    );

    // Branch offset counts instructions, so scale the signed dest by 4.
    assign br_off = {{(PC_W-10){ir_q[DST_LSB+7]}},
                     ir_q[DST_LSB +: 8], 2'b00};
    assign take   = dec_q.is_jump | (dec_q.is_branch & ALU_ZERO);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            dec_q   <= '0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            dec_q   <= dec_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        dec_d   = dec_q;
        ill_d   = ill_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_FETCH: begin
                if (IMEM_VALID) begin
                    ir_d    = IMEM_DATA;
                    dec_d   = dec_in;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_q.illegal) begin
                    ill_d   = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    cnt_d   = WAIT_INIT;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    state_d = ST_WB;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_WB: begin
                pc_d    = pc_q + PC_STEP + (take ? br_off : '0);
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Request is masked by reset so it reads 0 while RESET_N is low.
    always_comb begin
        IMEM_REQ  = RESET_N & (state_q == ST_FETCH);
        WEN       = (state_q == ST_WB) & dec_q.writes_reg;
        IMEM_ADDR = pc_q;
        PC        = pc_q;
        ILLEGAL   = ill_q;
        ALU_SEL   = dec_q.alu_sel;
        TWOS_SEL  = dec_q.twos_sel;
        IMM_SEL   = dec_q.imm_sel;
        IMM       = ir_q[IN2_LSB +: 8];
        RADDR1    = ir_q[IN1_LSB +: 3];
        RADDR2    = ir_q[IN2_LSB +: 3];
        WADDR     = ir_q[DST_LSB +: 3];
    end

endmodule
